// File: rtl/wb_uart_tx_if.sv
// Wishbone bus bundle between the interconnect (master) and a peripheral (slave).
//   adr    word address from the master
//   dat_w  write data, master -> slave
//   dat_r  read data, slave -> master, valid while ack is high
//   we     write enable
//   sel    byte lane selects
//   stb    strobe, cyc  bus cycle
//   ack    single-cycle transfer acknowledge
interface wb_bus;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic        we;
   logic [3:0]  sel;
   logic        stb;
   logic        cyc;
   logic        ack;

   modport master (output adr, dat_w, we, sel, stb, cyc, input dat_r, ack);
   modport slave  (input adr, dat_w, we, sel, stb, cyc, output dat_r, ack);
endinterface

// File: rtl/wb_uart_tx.sv
// Buffered 8N1 UART transmitter behind a Wishbone slave port.
// Firmware pushes bytes into a TX FIFO; a baud FSM shifts them out LSB first.
//   clk_in     system clock, rising edge
//   reset_in   synchronous reset, active-high
//   bus_slave  Wishbone slave (DATA 0x0, STATUS 0x4, DIVISOR 0x8, reserved 0xC)
//   tx_out     serial line, idles high
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | line high, pop next byte when FIFO non-empty
// ST_START | start bit (low) for div cycles
// ST_DATA  | 8 data bits, LSB first, div cycles each
// ST_STOP  | stop bit (high) for div cycles
module wb_uart_tx #(
   parameter int FIFO_DEPTH      = 8,
   parameter int DEFAULT_DIVISOR = 434
) (
   input  logic   clk_in,
   input  logic   reset_in,
   wb_bus.slave   bus_slave,
   output logic   tx_out
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam logic [1:0] A_DATA   = 2'd0;
   localparam logic [1:0] A_STATUS = 2'd1;
   localparam logic [1:0] A_DIV    = 2'd2;

   logic          ack_q;
   logic [31:0]   rdata_q, rdata_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q;
   logic [15:0]   divisor_q;
   logic [1:0]    state_q, state_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    bit_q, bit_d;
   logic [15:0]   baud_q, baud_d;
   logic [15:0]   div_q, div_d;

   logic          req, xfer, push, push_ok, pop, full, empty, busy;
   logic [1:0]    reg_sel;
   logic [15:0]   div_eff;
   logic          bus_unused;

   assign reg_sel = bus_slave.adr[3:2];
   assign req     = bus_slave.stb & bus_slave.cyc & ~ack_q;
   // Register side effects fire on the edge that ends the ACK cycle, so each
   // transfer acts exactly once.
   assign xfer    = ack_q & bus_slave.stb & bus_slave.cyc & bus_slave.we;
   assign push    = xfer & (reg_sel == A_DATA) & bus_slave.sel[0];
   assign full    = (count_q == CW'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   // Full is judged on the registered count: a same-cycle pop does not rescue the push.
   assign push_ok = push & ~full;
   assign pop     = (state_q == ST_IDLE) & ~empty;
   assign busy    = (state_q != ST_IDLE) | ~empty;
   assign div_eff = (divisor_q == 16'd0) ? 16'd1 : divisor_q;
   assign count_d = count_q + CW'(push_ok) - CW'(pop);

   assign bus_unused = ^{bus_slave.adr[31:4], bus_slave.adr[1:0],
                         bus_slave.dat_w[31:16], bus_slave.sel[3:1]};

   assign bus_slave.ack   = ack_q;
   assign bus_slave.dat_r = rdata_q;

   always_comb begin
      rdata_d = '0;
      if (req) begin
         case (reg_sel)
            A_STATUS: rdata_d = {20'd0, 4'(count_q), 4'd0, ovf_q, empty, full, busy};
            A_DIV:    rdata_d = {16'd0, divisor_q};
            default:  rdata_d = '0;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      baud_d  = baud_q;
      div_d   = div_q;
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               shift_d = mem_q[rd_ptr_q];
               div_d   = div_eff;
               baud_d  = div_eff - 16'd1;
               bit_d   = 3'd0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (baud_q == 16'd0) begin
               baud_d  = div_q - 16'd1;
               state_d = ST_DATA;
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         ST_DATA: begin
            if (baud_q == 16'd0) begin
               baud_d = div_q - 16'd1;
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  shift_d = {1'b0, shift_q[7:1]};
                  bit_d   = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         default: begin
            if (baud_q == 16'd0) begin
               state_d = ST_IDLE;
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
      endcase
   end

   always_comb begin
      case (state_q)
         ST_START: tx_out = 1'b0;
         ST_DATA:  tx_out = shift_q[0];
         default:  tx_out = 1'b1;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= bus_slave.dat_w[7:0];
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         ack_q     <= 1'b0;
         rdata_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         divisor_q <= 16'(DEFAULT_DIVISOR);
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_q     <= '0;
         baud_q    <= '0;
         div_q     <= 16'd1;
      end else begin
         ack_q   <= req;
         rdata_q <= rdata_d;
         count_q <= count_d;
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (push & full) begin
            ovf_q <= 1'b1;
         end else if (xfer && reg_sel == A_STATUS && bus_slave.dat_w[3]) begin
            ovf_q <= 1'b0;
         end
         if (xfer && reg_sel == A_DIV) begin
            divisor_q <= bus_slave.dat_w[15:0];
         end
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         baud_q  <= baud_d;
         div_q   <= div_d;
      end
   end

endmodule

// File: tb/tb_wb_uart_tx.sv
module tb_wb_uart_tx;

   logic clk = 1'b0;
   logic rst;
   logic tx;
   int   total = 0;
   int   bad   = 0;

   wb_bus bus ();

   wb_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIVISOR(434)) dut (
      .clk_in    (clk),
      .reset_in  (rst),
      .bus_slave (bus),
      .tx_out    (tx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [31:0] wdat;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic bus_idle();
      bus.stb = 1'b0;
      bus.cyc = 1'b0;
      bus.we  = 1'b0;
   endtask

   // Called at #1 after an edge; returns at #1 in the cycle after the ACK edge.
   task automatic wb_xfer(input logic [31:0] a, input logic we, input logic [31:0] d,
                          input bit keep, output logic [31:0] rd);
      bit got;
      bus.adr   = a;
      bus.dat_w = d;
      bus.we    = we;
      bus.sel   = 4'hF;
      bus.stb   = 1'b1;
      bus.cyc   = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         if (bus.ack) got = 1'b1;
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL ack_timeout: got no ack required ack within 8 cycles, adr %h", a);
      end
      rd = bus.dat_r;
      @(posedge clk); #1;
      check("ack_pulse", {31'd0, bus.ack}, 32'd0);
      if (!keep) bus_idle();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit keep);
      logic [31:0] dummy;
      wb_xfer(a, 1'b1, d, keep, dummy);
   endtask

   task automatic rd_reg(input logic [31:0] a, input bit keep, output logic [31:0] v);
      wb_xfer(a, 1'b0, 32'd0, keep, v);
   endtask

   task automatic wait_start(input string nm);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (tx === 1'b0) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL %s: got no start bit required start within 2000 cycles", nm);
      end
   endtask

   // Entered at #1 in the first start-bit cycle; returns in the last stop-bit cycle.
   task automatic check_frame(input logic [7:0] b, input int div, input string nm);
      int    errs;
      int    bi;
      logic  exp;
      errs = 0;
      for (int i = 0; i < 10 * div; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
         end
         bi = i / div;
         if (bi == 0)      exp = 1'b0;
         else if (bi == 9) exp = 1'b1;
         else              exp = b[bi-1];
         if (tx !== exp) errs++;
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL %s: got %0d wrong cycles required 0 (byte %h div %0d)", nm, errs, b, div);
      end
   endtask

   task automatic gap_then_next(input string nm);
      @(posedge clk); #1;
      check(nm, {31'd0, tx}, 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] v;
      int          errs;
      bit          drained;

      vecs[0]  = '{32'h04, 1'b0, 32'h0,        32'h0000_0004};
      vecs[1]  = '{32'h08, 1'b0, 32'h0,        32'd434};
      vecs[2]  = '{32'h00, 1'b0, 32'h0,        32'h0};
      vecs[3]  = '{32'h0C, 1'b0, 32'h0,        32'h0};
      vecs[4]  = '{32'h08, 1'b1, 32'hABCD1234, 32'h0};
      vecs[5]  = '{32'h08, 1'b0, 32'h0,        32'h0000_1234};
      vecs[6]  = '{32'h0C, 1'b1, 32'hFFFFFFFF, 32'h0};
      vecs[7]  = '{32'h0C, 1'b0, 32'h0,        32'h0};
      vecs[8]  = '{32'h04, 1'b1, 32'hFFFFFFFF, 32'h0};
      vecs[9]  = '{32'h04, 1'b0, 32'h0,        32'h0000_0004};
      vecs[10] = '{32'h18, 1'b0, 32'h0,        32'h0000_1234};
      vecs[11] = '{32'h08, 1'b1, 32'h4,        32'h0};
      vecs[12] = '{32'h08, 1'b0, 32'h0,        32'h4};

      bus.adr = '0; bus.dat_w = '0; bus.sel = '0;
      bus_idle();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_ack", {31'd0, bus.ack}, 32'd0);
      check("rst_rdata", bus.dat_r, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // register map vectors
      for (int i = 0; i < 13; i++) begin
         wb_xfer(vecs[i].adr, vecs[i].we, vecs[i].wdat, 1'b0, v);
         if (!vecs[i].we) check($sformatf("vec%0d", i), v, vecs[i].exp);
      end

      // single byte, latency and waveform at div 4
      wr(32'h0, 32'hA5, 1'b0);
      check("lat_idle", {31'd0, tx}, 32'd1);
      @(posedge clk); #1;
      check("lat_start", {31'd0, tx}, 32'd0);
      check_frame(8'hA5, 4, "frame_a5");
      @(posedge clk); #1;
      check("idle_after_a5", {31'd0, tx}, 32'd1);

      // overflow with div 2
      wr(32'h8, 32'd2, 1'b0);
      for (int k = 0; k < 9; k++) wr(32'h0, 32'h10 + k, 1'b1);
      rd_reg(32'h4, 1'b1, v);
      check("full_no_ovf", v & 32'hA, 32'h2);
      wr(32'h0, 32'h99, 1'b0);
      rd_reg(32'h4, 1'b0, v);
      check("ovf_full", v & 32'hA, 32'hA);
      wr(32'h4, 32'h8, 1'b0);
      rd_reg(32'h4, 1'b0, v);
      check("ovf_clear", v & 32'h8, 32'h0);
      drained = 1'b0;
      for (int i = 0; i < 200 && !drained; i++) begin
         rd_reg(32'h4, 1'b0, v);
         if (v == 32'h4) drained = 1'b1;
      end
      check("drain", {31'd0, drained}, 32'd1);

      // three contiguous frames at div 3
      wr(32'h8, 32'd3, 1'b0);
      fork
         begin
            wr(32'h0, 32'h5A, 1'b1);
            wr(32'h0, 32'hFF, 1'b1);
            wr(32'h0, 32'h01, 1'b0);
         end
         begin
            wait_start("start_f1");
            check_frame(8'h5A, 3, "f1");
            gap_then_next("gap1");
            check_frame(8'hFF, 3, "f2");
            gap_then_next("gap2");
            check_frame(8'h01, 3, "f3");
            @(posedge clk); #1;
            check("gap3", {31'd0, tx}, 32'd1);
         end
      join
      rd_reg(32'h4, 1'b0, v);
      check("idle_status", v, 32'h4);

      // divisor change mid-frame, then divisor 0
      fork
         begin
            wr(32'h0, 32'h3C, 1'b1);
            wr(32'h0, 32'hC3, 1'b1);
            wr(32'h8, 32'd6, 1'b0);
         end
         begin
            wait_start("start_d3");
            check_frame(8'h3C, 3, "div3_frame");
            gap_then_next("gap_div");
            check_frame(8'hC3, 6, "div6_frame");
         end
      join
      @(posedge clk); #1;
      wr(32'h8, 32'd0, 1'b0);
      wr(32'h0, 32'h96, 1'b0);
      wait_start("start_d0");
      check_frame(8'h96, 1, "div0_frame");
      @(posedge clk); #1;
      check("idle_after_d0", {31'd0, tx}, 32'd1);

      // reset mid-DATA with bytes queued and a pending strobe
      wr(32'h8, 32'd4, 1'b0);
      wr(32'h0, 32'h11, 1'b1);
      wr(32'h0, 32'h22, 1'b1);
      wr(32'h0, 32'h33, 1'b0);
      wait_start("start_rst");
      repeat (8) @(posedge clk);
      #1;
      rst       = 1'b1;
      bus.adr   = 32'h0;
      bus.dat_w = 32'h77;
      bus.we    = 1'b1;
      bus.stb   = 1'b1;
      bus.cyc   = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_tx", {31'd0, tx}, 32'd1);
      check("rst_mid_ack", {31'd0, bus.ack}, 32'd0);
      rst = 1'b0;
      bus_idle();
      errs = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (bus.ack !== 1'b0 || tx !== 1'b1) errs++;
      end
      check("quiet_after_rst", errs, 32'd0);
      rd_reg(32'h4, 1'b0, v);
      check("status_after_rst", v, 32'h4);
      rd_reg(32'h8, 1'b0, v);
      check("div_after_rst", v, 32'd434);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
